// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
//
// Receive side of the 16-bit serial link. While enable is high, one bit of
// din is sampled on every rising clock edge, LSB first. Each completed
// WIDTH-bit frame is presented on dout and flagged with dout_valid.
//
// Optional feature macro: DESER_HANDSHAKE_EN
//   undefined : dout_valid is a one-cycle pulse after each completed frame.
//   defined   : adds dout_ready / overrun. dout_valid holds until accepted;
//               a completion that overwrites an unaccepted word sets the
//               sticky overrun flag.
//
// Parameters
//   WIDTH       frame width in bits (power of 2, >= 2)
//   CNT_W       width of the bit-index counter
//
// Ports
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous active-high reset, clears all state
//   enable      in   1      frame-active qualifier; low returns to idle
//   din         in   1      serial data, sampled when enable is high
//   dout_ready  in   1      (handshake build) consumer accepts dout
//   dout        out  WIDTH  last completed frame, bit i = i-th sampled bit
//   dout_valid  out  1      completed-frame indicator
//   overrun     out  1      (handshake build) sticky lost-word flag
//   bit_cnt     out  CNT_W  index of the next bit to be sampled
// ---------------------------------------------------------------------------
module deserializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             din,
`ifdef DESER_HANDSHAKE_EN
    input  logic             dout_ready,
    output logic             overrun,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    // Only WIDTH-1 bits need storage: the final bit goes straight from din
    // into dout on the completion edge.
    logic [WIDTH-2:0]   shift_reg;
    logic [WIDTH-2:0]   shift_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [WIDTH-1:0]   dout_next;
    logic               valid_next;
    logic               frame_done;
`ifdef DESER_HANDSHAKE_EN
    logic               overrun_next;
`endif

    // Next-state, counter and shift-register update. Bits are written in
    // place at their final position, so the register never needs clearing
    // between frames: every position is overwritten before it is used.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shift_next = shift_reg;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    shift_next[0] = din;
                    cnt_next      = CNT_W'(1);
                    state_next    = RECV;
                end else begin
                    cnt_next      = '0;
                end
            end

            RECV: begin
                if (enable) begin
                    for (int i = 0; i < WIDTH - 1; i++) begin
                        if (bit_cnt == CNT_W'(i)) begin
                            shift_next[i] = din;
                        end
                    end
                    // Natural wrap of the power-of-2 counter starts the
                    // next frame with no bubble.
                    cnt_next = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        frame_done = 1'b1;
                    end
                end else begin
                    // Dropping enable abandons any partial frame.
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Output word and valid/overrun tracking.
    always_comb begin
        dout_next  = dout;
        if (frame_done) begin
            dout_next = {din, shift_reg};
        end

`ifdef DESER_HANDSHAKE_EN
        valid_next   = dout_valid;
        overrun_next = overrun;
        if (frame_done) begin
            // A new word always loads; if the previous one was still
            // pending and not taken on this edge, it is lost.
            valid_next = 1'b1;
            if (dout_valid && !dout_ready) begin
                overrun_next = 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            valid_next = 1'b0;
        end
`else
        valid_next = frame_done;
`endif
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
`ifdef DESER_HANDSHAKE_EN
            overrun    <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            bit_cnt    <= cnt_next;
            shift_reg  <= shift_next;
            dout       <= dout_next;
            dout_valid <= valid_next;
`ifdef DESER_HANDSHAKE_EN
            overrun    <= overrun_next;
`endif
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
//
// Directed testbench for deserializer (WIDTH = 16). Inputs are driven on the
// falling edge; outputs are sampled on the falling edge. Expected words are
// queued when the last bit of a frame is driven and popped by a monitor
// whenever the DUT presents (and, in the handshake build, hands over) a word.
// Define DESER_HANDSHAKE_EN for both files to exercise the handshake build.
// ---------------------------------------------------------------------------
module tb_deserializer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             din;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CNT_W-1:0] bit_cnt;
`ifdef DESER_HANDSHAKE_EN
    logic             overrun;
`endif

    int               checks;
    int               errors;
    int               cyc;
    int               t_first;
    int               t_second;
    bit               sb_on;
    logic [WIDTH-1:0] exp_q[$];

    deserializer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .din        (din),
`ifdef DESER_HANDSHAKE_EN
        .dout_ready (dout_ready),
        .overrun    (overrun),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .bit_cnt    (bit_cnt)
    );

    // 10-unit clock period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Free-running cycle counter used to measure the spacing of valid pulses.
    always @(posedge clock) begin
        cyc <= cyc + 1;
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives nbits of word LSB first, one bit per falling edge. Must be
    // entered on a falling edge; returns on the falling edge after the last
    // sampling edge. A full frame queues its expected word.
    task automatic applyStimulus(input logic [WIDTH-1:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            enable = 1'b1;
            din    = word[i];
            if (i == WIDTH - 1 && sb_on) begin
                exp_q.push_back(word);
            end
            @(negedge clock);
        end
    endtask

    // Scoreboard monitor: every word handed over must be the next expected.
    always @(negedge clock) begin
        if (!reset && sb_on && dout_valid && dout_ready) begin
            checkOutput("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                checkOutput("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        sb_on      = 1'b1;
        reset      = 1'b1;
        enable     = 1'b0;
        din        = 1'b0;
        dout_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clock);
        checkOutput("reset_dout",    32'(dout),       32'h0);
        checkOutput("reset_valid",   32'(dout_valid), 32'h0);
        checkOutput("reset_bit_cnt", 32'(bit_cnt),    32'h0);
        reset = 1'b0;

        // Single frame; valid lasts exactly one cycle.
        applyStimulus(16'hA5C3, 16);
        checkOutput("t1_dout",    32'(dout),       32'hA5C3);
        checkOutput("t1_valid",   32'(dout_valid), 32'h1);
        checkOutput("t1_bit_cnt", 32'(bit_cnt),    32'h0);
        enable = 1'b0;
        din    = 1'b1;
        @(negedge clock);
        checkOutput("t1_valid_drop", 32'(dout_valid), 32'h0);
        checkOutput("t1_dout_hold",  32'(dout),       32'hA5C3);

        // Back-to-back frames, counter wraps between them.
        applyStimulus(16'h1234, 16);
        t_first = cyc;
        checkOutput("t2_dout_a",    32'(dout),       32'h1234);
        checkOutput("t2_valid_a",   32'(dout_valid), 32'h1);
        checkOutput("t2_bit_cnt_a", 32'(bit_cnt),    32'h0);
        applyStimulus(16'hFFFF, 16);
        t_second = cyc;
        checkOutput("t2_dout_b",    32'(dout),       32'hFFFF);
        checkOutput("t2_valid_b",   32'(dout_valid), 32'h1);
        checkOutput("t2_spacing",   32'(t_second - t_first), 32'd16);

        // Partial frame abandoned, one idle cycle, then a fresh frame.
        applyStimulus(16'hFFFF, 7);
        checkOutput("t3_bit_cnt_mid", 32'(bit_cnt),    32'h7);
        checkOutput("t3_valid_mid",   32'(dout_valid), 32'h0);
        enable = 1'b0;
        din    = 1'($urandom_range(1));
        @(negedge clock);
        checkOutput("t3_bit_cnt_idle", 32'(bit_cnt),    32'h0);
        checkOutput("t3_valid_idle",   32'(dout_valid), 32'h0);
        checkOutput("t3_dout_idle",    32'(dout),       32'hFFFF);
        applyStimulus(16'h0001, 16);
        checkOutput("t3_dout",  32'(dout),       32'h0001);
        checkOutput("t3_valid", 32'(dout_valid), 32'h1);

        // Asynchronous reset mid-frame.
        applyStimulus(16'hBEEF, 9);
        checkOutput("t4_bit_cnt_mid", 32'(bit_cnt), 32'h9);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("t4_reset_dout",    32'(dout),       32'h0);
        checkOutput("t4_reset_valid",   32'(dout_valid), 32'h0);
        checkOutput("t4_reset_bit_cnt", 32'(bit_cnt),    32'h0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(16'h00F0, 16);
        checkOutput("t4_dout",  32'(dout),       32'h00F0);
        checkOutput("t4_valid", 32'(dout_valid), 32'h1);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);

`ifdef DESER_HANDSHAKE_EN
        // Unaccepted word overwritten -> overrun, valid held until accepted.
        sb_on      = 1'b0;
        dout_ready = 1'b0;
        applyStimulus(16'h1111, 16);
        checkOutput("t5_dout_a",    32'(dout),       32'h1111);
        checkOutput("t5_valid_a",   32'(dout_valid), 32'h1);
        checkOutput("t5_overrun_a", 32'(overrun),    32'h0);
        applyStimulus(16'h2222, 16);
        checkOutput("t5_dout_b",    32'(dout),       32'h2222);
        checkOutput("t5_valid_b",   32'(dout_valid), 32'h1);
        checkOutput("t5_overrun_b", 32'(overrun),    32'h1);
        enable = 1'b0;
        @(negedge clock);
        checkOutput("t5_valid_held", 32'(dout_valid), 32'h1);
        dout_ready = 1'b1;
        @(negedge clock);
        checkOutput("t5_valid_accepted", 32'(dout_valid), 32'h0);
        checkOutput("t5_overrun_sticky", 32'(overrun),    32'h1);
        @(negedge clock);
        checkOutput("t5_overrun_still", 32'(overrun), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("t5_overrun_reset", 32'(overrun), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Consumer always ready: every word handed over once, no overrun.
        sb_on = 1'b1;
        applyStimulus(16'hCAFE, 16);
        checkOutput("t6_overrun_a", 32'(overrun), 32'h0);
        applyStimulus(16'h0F0F, 16);
        checkOutput("t6_overrun_b", 32'(overrun), 32'h0);
        applyStimulus(16'h8001, 16);
        checkOutput("t6_dout_c",    32'(dout),    32'h8001);
        checkOutput("t6_overrun_c", 32'(overrun), 32'h0);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("t6_valid_idle", 32'(dout_valid),   32'h0);
        checkOutput("t6_sb_drained", 32'(exp_q.size()), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
